// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source result FIFOs (ALU, LSB) drained round-robin
// into one registered broadcast per cycle; flushed by roll_back, paused by rdy_in.
module cdb_arbiter #(
  parameter int ENTRY_W    = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               roll_back,
  input  logic               alu_valid_in,
  input  logic [ENTRY_W-1:0] alu_entry_in,
  input  logic [31:0]        alu_value_in,
  input  logic [31:0]        alu_pc_in,
  output logic               alu_full_out,
  input  logic               lsb_valid_in,
  input  logic [ENTRY_W-1:0] lsb_entry_in,
  input  logic [31:0]        lsb_value_in,
  output logic               lsb_full_out,
  output logic               cdb_valid_out,
  output logic               cdb_src_out,
  output logic [ENTRY_W-1:0] cdb_entry_out,
  output logic [31:0]        cdb_value_out,
  output logic [31:0]        cdb_pc_out
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic {SRC_ALU = 1'b0, SRC_LSB = 1'b1} src_e;

  typedef struct packed {
    logic [ENTRY_W-1:0] entry;
    logic [31:0]        value;
    logic [31:0]        pc;
  } alu_item_t;

  typedef struct packed {
    logic [ENTRY_W-1:0] entry;
    logic [31:0]        value;
  } lsb_item_t;

  alu_item_t        alu_mem [FIFO_DEPTH];
  lsb_item_t        lsb_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] alu_wr_ptr, alu_rd_ptr;
  logic [PTR_W-1:0] lsb_wr_ptr, lsb_rd_ptr;
  logic [CNT_W-1:0] alu_cnt, lsb_cnt;
  src_e             rr_last;

  logic alu_empty, lsb_empty;
  logic gnt_alu, gnt_lsb;
  logic advance;
  logic alu_push, alu_pop, lsb_push, lsb_pop;

  function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] cnt,
                                                 input logic push, input logic pop);
    if (push && !pop)      return cnt + CNT_W'(1);
    else if (pop && !push) return cnt - CNT_W'(1);
    else                   return cnt;
  endfunction

  assign alu_full_out = (alu_cnt == FULL_CNT);
  assign lsb_full_out = (lsb_cnt == FULL_CNT);
  assign alu_empty    = (alu_cnt == '0);
  assign lsb_empty    = (lsb_cnt == '0);
  assign advance      = rdy_in && !roll_back;

  // Arbitration looks only at occupancy before this cycle's pushes, so nothing bypasses.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    gnt_alu = 1'b0;
    gnt_lsb = 1'b0;
    if (!alu_empty && !lsb_empty) begin
      if (rr_last == SRC_ALU) gnt_lsb = 1'b1;
      else                    gnt_alu = 1'b1;
    end else if (!alu_empty) begin
      gnt_alu = 1'b1;
    end else if (!lsb_empty) begin
      gnt_lsb = 1'b1;
    end
  end

  assign alu_push = advance && alu_valid_in && !alu_full_out;
  assign lsb_push = advance && lsb_valid_in && !lsb_full_out;
  assign alu_pop  = advance && gnt_alu;
  assign lsb_pop  = advance && gnt_lsb;

  // NOTE: FIFO storage has no reset; the counts alone decide which slots are live.
  always_ff @(posedge clk_in) begin
    if (alu_push) alu_mem[alu_wr_ptr] <= '{entry: alu_entry_in, value: alu_value_in, pc: alu_pc_in};
    if (lsb_push) lsb_mem[lsb_wr_ptr] <= '{entry: lsb_entry_in, value: lsb_value_in};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      alu_wr_ptr <= '0;
      alu_rd_ptr <= '0;
      alu_cnt    <= '0;
      lsb_wr_ptr <= '0;
      lsb_rd_ptr <= '0;
      lsb_cnt    <= '0;
    end else if (rdy_in) begin
      if (roll_back) begin
        alu_wr_ptr <= '0;
        alu_rd_ptr <= '0;
        alu_cnt    <= '0;
        lsb_wr_ptr <= '0;
        lsb_rd_ptr <= '0;
        lsb_cnt    <= '0;
      end else begin
        if (alu_push) alu_wr_ptr <= alu_wr_ptr + PTR_W'(1);
        if (alu_pop)  alu_rd_ptr <= alu_rd_ptr + PTR_W'(1);
        if (lsb_push) lsb_wr_ptr <= lsb_wr_ptr + PTR_W'(1);
        if (lsb_pop)  lsb_rd_ptr <= lsb_rd_ptr + PTR_W'(1);
        alu_cnt <= next_cnt(alu_cnt, alu_push, alu_pop);
        lsb_cnt <= next_cnt(lsb_cnt, lsb_push, lsb_pop);
      end
    end
  end

  // Broadcast registers: payload holds when idle, only the valid bit drops.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cdb_valid_out <= 1'b0;
      cdb_src_out   <= 1'b0;
      cdb_entry_out <= '0;
      cdb_value_out <= '0;
      cdb_pc_out    <= '0;
      rr_last       <= SRC_LSB;
    end else if (rdy_in) begin
      if (roll_back) begin
        cdb_valid_out <= 1'b0;
        rr_last       <= SRC_LSB;
      end else if (gnt_alu) begin
        cdb_valid_out <= 1'b1;
        cdb_src_out   <= SRC_ALU;
        cdb_entry_out <= alu_mem[alu_rd_ptr].entry;
        cdb_value_out <= alu_mem[alu_rd_ptr].value;
        cdb_pc_out    <= alu_mem[alu_rd_ptr].pc;
        rr_last       <= SRC_ALU;
      end else if (gnt_lsb) begin
        cdb_valid_out <= 1'b1;
        cdb_src_out   <= SRC_LSB;
        cdb_entry_out <= lsb_mem[lsb_rd_ptr].entry;
        cdb_value_out <= lsb_mem[lsb_rd_ptr].value;
        cdb_pc_out    <= '0;
        rr_last       <= SRC_LSB;
      end else begin
        cdb_valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: hand-traced broadcast order, full flags,
// roll_back flush, rdy_in stall and asynchronous reset.
module tb_cdb_arbiter;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        roll_back;
  logic        alu_valid_in;
  logic [4:0]  alu_entry_in;
  logic [31:0] alu_value_in;
  logic [31:0] alu_pc_in;
  logic        alu_full_out;
  logic        lsb_valid_in;
  logic [4:0]  lsb_entry_in;
  logic [31:0] lsb_value_in;
  logic        lsb_full_out;
  logic        cdb_valid_out;
  logic        cdb_src_out;
  logic [4:0]  cdb_entry_out;
  logic [31:0] cdb_value_out;
  logic [31:0] cdb_pc_out;

  int n_checks = 0;
  int n_pass   = 0;

  cdb_arbiter #(.ENTRY_W(5), .FIFO_DEPTH(4), .CNT_W(3)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .roll_back     (roll_back),
    .alu_valid_in  (alu_valid_in),
    .alu_entry_in  (alu_entry_in),
    .alu_value_in  (alu_value_in),
    .alu_pc_in     (alu_pc_in),
    .alu_full_out  (alu_full_out),
    .lsb_valid_in  (lsb_valid_in),
    .lsb_entry_in  (lsb_entry_in),
    .lsb_value_in  (lsb_value_in),
    .lsb_full_out  (lsb_full_out),
    .cdb_valid_out (cdb_valid_out),
    .cdb_src_out   (cdb_src_out),
    .cdb_entry_out (cdb_entry_out),
    .cdb_value_out (cdb_value_out),
    .cdb_pc_out    (cdb_pc_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Tags 0..15 come from the ALU, 16..31 from the LSB; payloads derive from the tag.
  function automatic logic [31:0] val_of(input logic [4:0] e);
    return 32'hA000 + {27'd0, e};
  endfunction

  function automatic logic [31:0] pc_of(input logic [4:0] e);
    return (e >= 5'd16) ? 32'd0 : 32'h1000 + {25'd0, e, 2'b00};
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_inputs();
    alu_valid_in = 1'b0;
    lsb_valid_in = 1'b0;
    roll_back    = 1'b0;
  endtask

  task automatic set_alu(input logic [4:0] e);
    alu_valid_in = 1'b1;
    alu_entry_in = e;
    alu_value_in = val_of(e);
    alu_pc_in    = pc_of(e);
  endtask

  task automatic set_lsb(input logic [4:0] e);
    lsb_valid_in = 1'b1;
    lsb_entry_in = e;
    lsb_value_in = val_of(e);
  endtask

  task automatic exp_idle(input string tag);
    check({tag, "_valid"}, 32'(cdb_valid_out), 32'd0);
  endtask

  task automatic exp_bcast(input string tag, input logic src, input logic [4:0] e,
                           input logic [31:0] val, input logic [31:0] pc);
    check({tag, "_valid"}, 32'(cdb_valid_out), 32'd1);
    check({tag, "_src"},   32'(cdb_src_out),   32'(src));
    check({tag, "_entry"}, 32'(cdb_entry_out), 32'(e));
    check({tag, "_value"}, cdb_value_out,      val);
    check({tag, "_pc"},    cdb_pc_out,         pc);
  endtask

  task automatic expect_tag(input string tag, input logic [4:0] e);
    exp_bcast(tag, e >= 5'd16, e, val_of(e), pc_of(e));
  endtask

  task automatic exp_reset(input string tag);
    check({tag, "_valid"}, 32'(cdb_valid_out), 32'd0);
    check({tag, "_src"},   32'(cdb_src_out),   32'd0);
    check({tag, "_entry"}, 32'(cdb_entry_out), 32'd0);
    check({tag, "_value"}, cdb_value_out,      32'd0);
    check({tag, "_pc"},    cdb_pc_out,         32'd0);
  endtask

  logic [4:0] t4_seq [12];

  initial begin
    rst_in       = 1'b0;
    rdy_in       = 1'b1;
    roll_back    = 1'b0;
    alu_valid_in = 1'b0;
    alu_entry_in = '0;
    alu_value_in = '0;
    alu_pc_in    = '0;
    lsb_valid_in = 1'b0;
    lsb_entry_in = '0;
    lsb_value_in = '0;

    // Reset state
    repeat (2) tick();
    exp_reset("rst");
    check("rst_alu_full", 32'(alu_full_out), 32'd0);
    check("rst_lsb_full", 32'(lsb_full_out), 32'd0);
    rst_in = 1'b1;

    // Single ALU push: visible only after the second edge, no bypass
    alu_valid_in = 1'b1;
    alu_entry_in = 5'd3;
    alu_value_in = 32'h55;
    alu_pc_in    = 32'h100;
    tick();
    clear_inputs();
    exp_idle("t2_no_bypass");
    tick();
    exp_bcast("t2_bcast", 1'b0, 5'd3, 32'h55, 32'h100);
    tick();
    exp_idle("t2_done");
    check("t2_hold_entry", 32'(cdb_entry_out), 32'd3);

    // roll_back restores the ALU-first tie break
    roll_back = 1'b1;
    tick();
    clear_inputs();
    exp_idle("rb_idle");

    // Contention: 1 (ALU), 2 (LSB), 4 (ALU), 5 (LSB)
    alu_valid_in = 1'b1; alu_entry_in = 5'd1; alu_value_in = 32'hA; alu_pc_in = 32'h200;
    lsb_valid_in = 1'b1; lsb_entry_in = 5'd2; lsb_value_in = 32'hB;
    tick();
    alu_entry_in = 5'd4; alu_value_in = 32'hC; alu_pc_in = 32'h204;
    lsb_entry_in = 5'd5; lsb_value_in = 32'hD;
    tick();
    clear_inputs();
    exp_bcast("t3_b1", 1'b0, 5'd1, 32'hA, 32'h200);
    tick();
    exp_bcast("t3_b2", 1'b1, 5'd2, 32'hB, 32'h0);
    tick();
    exp_bcast("t3_b3", 1'b0, 5'd4, 32'hC, 32'h204);
    tick();
    exp_bcast("t3_b4", 1'b1, 5'd5, 32'hD, 32'h0);
    tick();
    exp_idle("t3_done");

    // Fill the LSB FIFO under contention; 7th LSB push (tag 26) hits a full FIFO and is dropped
    t4_seq = '{5'd10, 5'd20, 5'd11, 5'd21, 5'd12, 5'd22,
               5'd13, 5'd23, 5'd14, 5'd24, 5'd15, 5'd25};
    for (int k = 1; k <= 14; k++) begin
      clear_inputs();
      if (k <= 6) set_alu(5'(9 + k));
      if (k <= 7) set_lsb(5'(19 + k));
      if (k == 7) check("t4_push_while_full_flagged", 32'(lsb_full_out), 32'd1);
      tick();
      check($sformatf("t4_alu_full_%0d", k), 32'(alu_full_out), 32'd0);
      check($sformatf("t4_lsb_full_%0d", k), 32'(lsb_full_out), 32'(k == 6));
      if (k >= 2 && k <= 13) expect_tag($sformatf("t4_bcast_%0d", k), t4_seq[k-2]);
      else                   exp_idle($sformatf("t4_idle_%0d", k));
    end
    clear_inputs();

    // Three ALU entries queued, then roll_back with a same-cycle push
    for (int k = 1; k <= 5; k++) begin
      clear_inputs();
      set_alu(5'(k));
      set_lsb(5'(16 + k));
      tick();
      case (k)
        1: exp_idle("t5_e1");
        2: expect_tag("t5_e2", 5'd1);
        3: expect_tag("t5_e3", 5'd17);
        4: expect_tag("t5_e4", 5'd2);
        default: expect_tag("t5_e5", 5'd18);
      endcase
    end
    roll_back = 1'b1;
    set_alu(5'd6);
    set_lsb(5'd22);
    tick();
    clear_inputs();
    exp_idle("t5_flush");
    check("t5_alu_full", 32'(alu_full_out), 32'd0);
    check("t5_lsb_full", 32'(lsb_full_out), 32'd0);
    check("t5_hold_entry", 32'(cdb_entry_out), 32'd18);
    tick();
    exp_idle("t5_empty1");
    tick();
    exp_idle("t5_empty2");
    set_alu(5'd8);
    tick();
    clear_inputs();
    exp_idle("t5_refill");
    tick();
    expect_tag("t5_first_after_flush", 5'd8);
    tick();
    exp_idle("t5_drained");

    // Draining run with a 3-cycle rdy_in stall; stall-time pushes must be ignored
    for (int k = 1; k <= 3; k++) begin
      clear_inputs();
      set_alu(5'(10 + k));
      set_lsb(5'(26 + k));
      tick();
      case (k)
        1: exp_idle("t6_e1");
        2: expect_tag("t6_e2", 5'd27);
        default: expect_tag("t6_e3", 5'd11);
      endcase
    end
    clear_inputs();
    tick();
    expect_tag("t6_e4", 5'd28);
    rdy_in = 1'b0;
    set_alu(5'd14);
    set_lsb(5'd30);
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_tag($sformatf("t6_stall_%0d", k), 5'd28);
    end
    clear_inputs();
    rdy_in = 1'b1;
    tick();
    expect_tag("t6_e8", 5'd12);
    tick();
    expect_tag("t6_e9", 5'd29);
    tick();
    expect_tag("t6_e10", 5'd13);
    tick();
    exp_idle("t6_e11");

    // Asynchronous reset pulse between edges
    set_alu(5'd7);
    tick();
    clear_inputs();
    tick();
    expect_tag("t7_pre", 5'd7);
    #1 rst_in = 1'b0;
    #1 exp_reset("t7_async");
    rst_in = 1'b1;
    set_alu(5'd9);
    tick();
    clear_inputs();
    exp_idle("t7_no_bypass");
    tick();
    expect_tag("t7_first_push", 5'd9);
    tick();
    exp_idle("t7_done");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
